// File: rtl/update_kl_if.sv
// Candidate-stack push channel: one survivor candidate per valid/ready transfer.
// Producer holds valid and all fields stable until the consumer returns ready.
interface update_kl_if #(
  parameter int W = 8
);
  logic         push_valid;
  logic         push_ready;
  logic [4:0]   push_position;
  logic [11:0]  push_addr;
  logic [W-1:0] push_i;
  logic [W-1:0] push_z;
  logic [W-1:0] push_k;
  logic [W-1:0] push_l;

  modport master (
    output push_valid, push_position, push_addr, push_i, push_z, push_k, push_l,
    input  push_ready
  );

  modport slave (
    input  push_valid, push_position, push_addr, push_i, push_z, push_k, push_l,
    output push_ready
  );
endinterface

// File: rtl/update_kl.sv
// Interval/counter update and classification of one candidate; enable-to-done 3 cycles (discard/hit), 4 (push).
// Backpressure: push held in PUSH until push_ready, one extra cycle per stalled cycle; new enables ignored while busy.
module update_kl #(
  parameter logic [2:0] EN_CODE = 3'b101,
  parameter int         W       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    en_update_kl,
  input  logic [4:0]    position,
  input  logic [11:0]   addr,
  input  logic [W-1:0]  i_in,
  input  logic [W-1:0]  z_in,
  input  logic [W-1:0]  k_in,
  input  logic [W-1:0]  l_in,
  input  logic [W-1:0]  c_base,
  input  logic [W-1:0]  occ_k,
  input  logic [W-1:0]  occ_l,
  update_kl_if.master   push,
  output logic          hit_valid,
  output logic [W-1:0]  hit_k,
  output logic [W-1:0]  hit_l,
  output logic          stop_seen,
  output logic          done,
  output logic          busy
);

  localparam logic [4:0] POS_A_MATCH = 5'd1;
  localparam logic [4:0] POS_T_MATCH = 5'd4;
  localparam logic [4:0] POS_A_SNP   = 5'd5;
  localparam logic [4:0] POS_T_SNP   = 5'd8;
  localparam logic [4:0] POS_A_DEL   = 5'd9;
  localparam logic [4:0] POS_T_DEL   = 5'd12;
  localparam logic [4:0] POS_A_INS   = 5'd13;
  localparam logic [4:0] POS_T_INS   = 5'd16;
  localparam logic [4:0] POS_STOP_1  = 5'd17;
  localparam logic [4:0] POS_STOP_2  = 5'd18;

  localparam logic [W+1:0] ONE_X = (W+2)'(1);
  localparam logic [W+1:0] MAX_X = (W+2)'((1 << W) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_CHECK, S_PUSH, S_RETIRE
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE, CL_MATCH, CL_SNP, CL_DEL, CL_INS, CL_STOP
  } cls_t;

  state_t state, state_nxt;
  cls_t   cls;

  logic [4:0]   cap_pos;
  logic [11:0]  cap_addr;
  logic [W-1:0] cap_i, cap_z, cap_k, cap_l, cap_c, cap_ok, cap_ol;

  logic [W-1:0] calc_i;
  logic [W+1:0] calc_z, calc_k, calc_l;
  logic         calc_discard, calc_hit;

  logic         dec_i, dec_z;
  logic [W-1:0] i_new;
  logic [W+1:0] z_ext, z_new, sum_k, sum_l, k_new, l_new;
  logic         reject;

  logic         pv_q, pv_nxt;
  logic [4:0]   ppos_q, ppos_nxt;
  logic [11:0]  paddr_q, paddr_nxt;
  logic [W-1:0] pi_q, pi_nxt, pz_q, pz_nxt, pk_q, pk_nxt, pl_q, pl_nxt;
  logic         hit_valid_nxt, stop_seen_nxt, done_nxt;
  logic [W-1:0] hit_k_nxt, hit_l_nxt;

  always_comb begin
    cls = CL_NONE;
    if (cap_pos >= POS_A_MATCH && cap_pos <= POS_T_MATCH)    cls = CL_MATCH;
    else if (cap_pos >= POS_A_SNP && cap_pos <= POS_T_SNP)   cls = CL_SNP;
    else if (cap_pos >= POS_A_DEL && cap_pos <= POS_T_DEL)   cls = CL_DEL;
    else if (cap_pos >= POS_A_INS && cap_pos <= POS_T_INS)   cls = CL_INS;
    else if (cap_pos == POS_STOP_1 || cap_pos == POS_STOP_2) cls = CL_STOP;
  end

  // Two guard bits let C+Occ overflow past 2^W and z go negative without wrapping.
  always_comb begin
    dec_i = (cls == CL_MATCH) || (cls == CL_SNP) || (cls == CL_INS);
    dec_z = (cls == CL_SNP) || (cls == CL_DEL) || (cls == CL_INS);
    i_new = dec_i ? (cap_i - W'(1)) : cap_i;
    z_ext = {{2{cap_z[W-1]}}, cap_z};
    z_new = dec_z ? (z_ext - ONE_X) : z_ext;
    sum_k = {2'b00, cap_c} + {2'b00, cap_ok} + ONE_X;
    sum_l = {2'b00, cap_c} + {2'b00, cap_ol};
    k_new = (cls == CL_INS) ? {2'b00, cap_k} : sum_k;
    l_new = (cls == CL_INS) ? {2'b00, cap_l} : sum_l;
  end

  always_comb begin
    reject = calc_discard
           || ($signed(calc_z) < $signed((W+2)'(0)))
           || (calc_k > calc_l)
           || (calc_k > MAX_X)
           || (calc_l > MAX_X);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_pos      <= '0;
      cap_addr     <= '0;
      cap_i        <= '0;
      cap_z        <= '0;
      cap_k        <= '0;
      cap_l        <= '0;
      cap_c        <= '0;
      cap_ok       <= '0;
      cap_ol       <= '0;
      calc_i       <= '0;
      calc_z       <= '0;
      calc_k       <= '0;
      calc_l       <= '0;
      calc_discard <= 1'b0;
      calc_hit     <= 1'b0;
    end else begin
      if (state == S_IDLE && en_update_kl == EN_CODE) begin
        cap_pos  <= position;
        cap_addr <= addr;
        cap_i    <= i_in;
        cap_z    <= z_in;
        cap_k    <= k_in;
        cap_l    <= l_in;
        cap_c    <= c_base;
        cap_ok   <= occ_k;
        cap_ol   <= occ_l;
      end
      if (state == S_CALC) begin
        calc_i       <= i_new;
        calc_z       <= z_new;
        calc_k       <= k_new;
        calc_l       <= l_new;
        calc_discard <= (cls == CL_NONE) || (cls == CL_STOP);
        calc_hit     <= dec_i && (cap_i == '0);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    pv_nxt        = pv_q;
    ppos_nxt      = ppos_q;
    paddr_nxt     = paddr_q;
    pi_nxt        = pi_q;
    pz_nxt        = pz_q;
    pk_nxt        = pk_q;
    pl_nxt        = pl_q;
    hit_k_nxt     = hit_k;
    hit_l_nxt     = hit_l;
    hit_valid_nxt = 1'b0;
    stop_seen_nxt = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        if (en_update_kl == EN_CODE) state_nxt = S_CALC;
      end
      S_CALC: begin
        stop_seen_nxt = (cls == CL_STOP);
        state_nxt     = S_CHECK;
      end
      S_CHECK: begin
        if (reject) begin
          state_nxt = S_RETIRE;
        end else if (calc_hit) begin
          hit_valid_nxt = 1'b1;
          hit_k_nxt     = calc_k[W-1:0];
          hit_l_nxt     = calc_l[W-1:0];
          state_nxt     = S_RETIRE;
        end else begin
          pv_nxt    = 1'b1;
          ppos_nxt  = cap_pos;
          paddr_nxt = cap_addr;
          pi_nxt    = calc_i;
          pz_nxt    = calc_z[W-1:0];
          pk_nxt    = calc_k[W-1:0];
          pl_nxt    = calc_l[W-1:0];
          state_nxt = S_PUSH;
        end
      end
      S_PUSH: begin
        if (push.push_ready) begin
          pv_nxt    = 1'b0;
          state_nxt = S_RETIRE;
        end
      end
      S_RETIRE: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pv_q      <= 1'b0;
      ppos_q    <= '0;
      paddr_q   <= '0;
      pi_q      <= '0;
      pz_q      <= '0;
      pk_q      <= '0;
      pl_q      <= '0;
      hit_valid <= 1'b0;
      hit_k     <= '0;
      hit_l     <= '0;
      stop_seen <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pv_q      <= pv_nxt;
      ppos_q    <= ppos_nxt;
      paddr_q   <= paddr_nxt;
      pi_q      <= pi_nxt;
      pz_q      <= pz_nxt;
      pk_q      <= pk_nxt;
      pl_q      <= pl_nxt;
      hit_valid <= hit_valid_nxt;
      hit_k     <= hit_k_nxt;
      hit_l     <= hit_l_nxt;
      stop_seen <= stop_seen_nxt;
      done      <= done_nxt;
    end
  end

  assign busy               = (state != S_IDLE);
  assign push.push_valid    = pv_q;
  assign push.push_position = ppos_q;
  assign push.push_addr     = paddr_q;
  assign push.push_i        = pi_q;
  assign push.push_z        = pz_q;
  assign push.push_k        = pk_q;
  assign push.push_l        = pl_q;

endmodule

// File: tb/tb_update_kl.sv
// Self-checking bench for update_kl: directed scenarios plus randomized candidates vs. an arithmetic model.
module tb_update_kl;
  localparam int         W  = 8;
  localparam logic [2:0] EN = 3'b101;

  localparam logic [4:0] A_MATCH = 5'd1,  C_MATCH = 5'd2, G_MATCH = 5'd3, T_MATCH = 5'd4;
  localparam logic [4:0] A_SNP   = 5'd5,  C_SNP   = 5'd6;
  localparam logic [4:0] A_DEL   = 5'd9,  T_INS   = 5'd16;
  localparam logic [4:0] STOP_1  = 5'd17;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   en_update_kl = '0;
  logic [4:0]   position = '0;
  logic [11:0]  addr = '0;
  logic [W-1:0] i_in = '0, z_in = '0, k_in = '0, l_in = '0;
  logic [W-1:0] c_base = '0, occ_k = '0, occ_l = '0;
  logic         hit_valid, stop_seen, done, busy;
  logic [W-1:0] hit_k, hit_l;

  update_kl_if #(.W(W)) pif ();

  update_kl #(.EN_CODE(EN), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en_update_kl(en_update_kl),
    .position(position), .addr(addr),
    .i_in(i_in), .z_in(z_in), .k_in(k_in), .l_in(l_in),
    .c_base(c_base), .occ_k(occ_k), .occ_l(occ_l),
    .push(pif.master),
    .hit_valid(hit_valid), .hit_k(hit_k), .hit_l(hit_l),
    .stop_seen(stop_seen), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observations gathered by run_cand
  int           o_done_cyc, o_push_cyc, o_unstable, o_hit_cnt, o_stop_cnt, o_overlap;
  logic [4:0]   o_ppos;
  logic [11:0]  o_paddr;
  logic [W-1:0] o_pi, o_pz, o_pk, o_pl, o_hk, o_hl;

  // Reference: the candidate's fate from the update rules, in plain integers.
  // kind: 0 push, 1 hit, 2 discard
  function automatic void model(input logic [4:0] p, input logic [7:0] i, z, k, l, c, ok, ol,
                                output int kind, output logic [7:0] ei, ez, ek, el, output bit stp);
    bit mt, sn, de, ins;
    int nk, nl, nz, ni;
    mt  = (p >= 1 && p <= 4);
    sn  = (p >= 5 && p <= 8);
    de  = (p >= 9 && p <= 12);
    ins = (p >= 13 && p <= 16);
    stp = (p == 17 || p == 18);
    nz  = int'($signed(z)) - ((sn || de || ins) ? 1 : 0);
    ni  = int'(i) - ((mt || sn || ins) ? 1 : 0);
    nk  = ins ? int'(k) : int'(c) + int'(ok) + 1;
    nl  = ins ? int'(l) : int'(c) + int'(ol);
    if (!(mt || sn || de || ins) || nz < 0 || nk > nl || nk > 255 || nl > 255) kind = 2;
    else if ((mt || sn || ins) && i == 0) kind = 1;
    else kind = 0;
    ei = ni[7:0];
    ez = nz[7:0];
    ek = nk[7:0];
    el = nl[7:0];
  endfunction

  // Drive one candidate and watch it retire; stall = cycles push_ready is held low while push is pending.
  task automatic run_cand(input logic [4:0] p, input logic [11:0] a,
                          input logic [7:0] i, z, k, l, c, ok, ol,
                          input int stall, input bit reen, input bit chained);
    int left;
    left = stall;
    o_done_cyc = 0; o_push_cyc = 0; o_unstable = 0;
    o_hit_cnt = 0; o_stop_cnt = 0; o_overlap = 0;
    if (!chained) @(negedge clk);
    position = p; addr = a; i_in = i; z_in = z; k_in = k; l_in = l;
    c_base = c; occ_k = ok; occ_l = ol;
    en_update_kl = EN;
    @(posedge clk);
    @(negedge clk);
    en_update_kl = reen ? EN : 3'b000;
    position = $urandom_range(0, 31);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 2) en_update_kl = 3'b000;
      if (pif.push_valid) begin
        if (o_push_cyc == 0) begin
          o_ppos = pif.push_position; o_paddr = pif.push_addr;
          o_pi = pif.push_i; o_pz = pif.push_z; o_pk = pif.push_k; o_pl = pif.push_l;
        end else if ({o_ppos, o_paddr, o_pi, o_pz, o_pk, o_pl} !==
                     {pif.push_position, pif.push_addr, pif.push_i, pif.push_z, pif.push_k, pif.push_l}) begin
          o_unstable++;
        end
        o_push_cyc++;
        if (left > 0) begin
          pif.push_ready = 1'b0;
          left--;
        end else begin
          pif.push_ready = 1'b1;
        end
      end else begin
        pif.push_ready = 1'b0;
      end
      if (hit_valid) begin
        o_hit_cnt++; o_hk = hit_k; o_hl = hit_l;
      end
      if (stop_seen) o_stop_cnt++;
      if ((hit_valid || stop_seen) && pif.push_valid) o_overlap++;
      if (done) begin
        o_done_cyc = cyc;
        break;
      end
    end
    pif.push_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, pif.push_valid, hit_valid, stop_seen, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: busy/pv/hit/stop/done=%b want 00000",
               {busy, pif.push_valid, hit_valid, stop_seen, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    position = A_MATCH; addr = 12'h123; i_in = 8'd5; z_in = 8'd1; k_in = 8'd3; l_in = 8'd9;
    c_base = 8'd10; occ_k = 8'd2; occ_l = 8'd6; en_update_kl = EN;
    @(posedge clk);
    @(negedge clk);
    en_update_kl = 3'b000;
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (pif.push_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_push_wait: push_valid never rose within 10 cycles");
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, pif.push_valid, done} !== 3'b0) begin
      errors++;
      $display("FAIL reset_midpush: busy/pv/done=%b want 000", {busy, pif.push_valid, done});
    end
    checks++;
    if ({pif.push_position, pif.push_addr, pif.push_i, pif.push_z, pif.push_k, pif.push_l,
         hit_valid, hit_k, hit_l, stop_seen} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: push fields %h/%h/%h/%h/%h/%h hit %b %h %h stop %b want all 0",
               pif.push_position, pif.push_addr, pif.push_i, pif.push_z, pif.push_k, pif.push_l,
               hit_valid, hit_k, hit_l, stop_seen);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_abandon: done/busy after reset got 1 want 0");
    end
  endtask

  task automatic test_match();
    run_cand(A_MATCH, 12'hABC, 8'd5, 8'd1, 8'd3, 8'd9, 8'd10, 8'd2, 8'd6, 0, 1'b0, 1'b0);
    checks++;
    if (o_done_cyc !== 4) begin
      errors++; $display("FAIL match_latency: done at %0d want 4", o_done_cyc);
    end
    checks++;
    if ({o_push_cyc, o_ppos, o_paddr, o_pi, o_pz, o_pk, o_pl} !==
        {32'd1, A_MATCH, 12'hABC, 8'd4, 8'd1, 8'd13, 8'd16}) begin
      errors++;
      $display("FAIL match_push: cnt=%0d i=%0d z=%0d k=%0d l=%0d want cnt=1 i=4 z=1 k=13 l=16",
               o_push_cyc, o_pi, o_pz, o_pk, o_pl);
    end
    checks++;
    if (o_hit_cnt !== 0 || o_stop_cnt !== 0) begin
      errors++; $display("FAIL match_nohit: hit=%0d stop=%0d want 0 0", o_hit_cnt, o_stop_cnt);
    end
  endtask

  task automatic test_snp_discard();
    run_cand(C_SNP, 12'h010, 8'd4, 8'd0, 8'd3, 8'd9, 8'd10, 8'd2, 8'd6, 0, 1'b0, 1'b0);
    checks++;
    if ({o_done_cyc, o_push_cyc, o_hit_cnt} !== {32'd3, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL snp_discard: done=%0d push=%0d hit=%0d want 3 0 0", o_done_cyc, o_push_cyc, o_hit_cnt);
    end
  endtask

  task automatic test_hit();
    run_cand(G_MATCH, 12'h020, 8'd0, 8'd0, 8'd1, 8'd50, 8'd20, 8'd4, 8'd7, 0, 1'b0, 1'b0);
    checks++;
    if ({o_hit_cnt, o_hk, o_hl} !== {32'd1, 8'd25, 8'd27}) begin
      errors++;
      $display("FAIL hit_values: pulses=%0d k=%0d l=%0d want 1 25 27", o_hit_cnt, o_hk, o_hl);
    end
    checks++;
    if ({o_done_cyc, o_push_cyc, o_overlap} !== {32'd3, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL hit_retire: done=%0d push=%0d overlap=%0d want 3 0 0", o_done_cyc, o_push_cyc, o_overlap);
    end
  endtask

  task automatic test_insertion_stall();
    run_cand(T_INS, 12'h777, 8'd3, 8'd2, 8'd7, 8'd7, 8'd90, 8'd11, 8'd12, 3, 1'b0, 1'b0);
    checks++;
    if ({o_push_cyc, o_unstable} !== {32'd4, 32'd0}) begin
      errors++;
      $display("FAIL ins_hold: valid cycles=%0d unstable=%0d want 4 0", o_push_cyc, o_unstable);
    end
    checks++;
    if ({o_pi, o_pz, o_pk, o_pl} !== {8'd2, 8'd1, 8'd7, 8'd7}) begin
      errors++;
      $display("FAIL ins_fields: i=%0d z=%0d k=%0d l=%0d want 2 1 7 7", o_pi, o_pz, o_pk, o_pl);
    end
    checks++;
    if (o_done_cyc !== 7) begin
      errors++; $display("FAIL ins_latency: done at %0d want 7", o_done_cyc);
    end
  endtask

  task automatic test_empty_interval();
    run_cand(A_DEL, 12'h030, 8'd6, 8'd2, 8'd0, 8'd100, 8'd5, 8'd8, 8'd7, 0, 1'b0, 1'b0);
    checks++;
    if ({o_done_cyc, o_push_cyc, o_hit_cnt} !== {32'd3, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL empty_interval: done=%0d push=%0d hit=%0d want 3 0 0", o_done_cyc, o_push_cyc, o_hit_cnt);
    end
  endtask

  task automatic test_stop();
    run_cand(STOP_1, 12'h040, 8'd2, 8'd1, 8'd1, 8'd9, 8'd1, 8'd1, 8'd5, 0, 1'b0, 1'b0);
    checks++;
    if ({o_stop_cnt, o_done_cyc, o_push_cyc, o_hit_cnt} !== {32'd1, 32'd3, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL stop: stop=%0d done=%0d push=%0d hit=%0d want 1 3 0 0",
               o_stop_cnt, o_done_cyc, o_push_cyc, o_hit_cnt);
    end
  endtask

  task automatic test_busy_ignore();
    bit extra;
    run_cand(T_MATCH, 12'h050, 8'd9, 8'd0, 8'd0, 8'd0, 8'd30, 8'd1, 8'd3, 1, 1'b1, 1'b0);
    checks++;
    if ({o_done_cyc, o_push_cyc, o_pi, o_pk, o_pl} !== {32'd5, 32'd2, 8'd8, 8'd32, 8'd33}) begin
      errors++;
      $display("FAIL busy_first: done=%0d push=%0d i=%0d k=%0d l=%0d want 5 2 8 32 33",
               o_done_cyc, o_push_cyc, o_pi, o_pk, o_pl);
    end
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy || pif.push_valid) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++; $display("FAIL busy_ignore: activity after retire got 1 want 0");
    end
  endtask

  task automatic test_back_to_back();
    run_cand(C_MATCH, 12'h060, 8'd2, 8'd3, 8'd0, 8'd0, 8'd40, 8'd5, 8'd9, 0, 1'b0, 1'b0);
    run_cand(A_SNP, 12'h061, 8'd7, 8'd3, 8'd0, 8'd0, 8'd60, 8'd0, 8'd2, 0, 1'b0, 1'b1);
    checks++;
    if ({o_done_cyc, o_push_cyc, o_pi, o_pz, o_pk, o_pl} !== {32'd4, 32'd1, 8'd6, 8'd2, 8'd61, 8'd62}) begin
      errors++;
      $display("FAIL back_to_back: done=%0d push=%0d i=%0d z=%0d k=%0d l=%0d want 4 1 6 2 61 62",
               o_done_cyc, o_push_cyc, o_pi, o_pz, o_pk, o_pl);
    end
  endtask

  task automatic test_random();
    logic [4:0] p;
    logic [7:0] i, z, k, l, c, ok, ol, ei, ez, ek, el;
    int kind, stall, want_done;
    bit stp;
    for (int n = 0; n < 60; n++) begin
      p  = 5'($urandom_range(0, 20));
      i  = 8'($urandom_range(0, 3));
      z  = 8'($urandom_range(0, 5)) - 8'd2;
      k  = 8'($urandom_range(0, 255));
      l  = 8'($urandom_range(0, 255));
      c  = 8'($urandom_range(0, 255));
      ok = 8'($urandom_range(0, 60));
      ol = ok + 8'($urandom_range(0, 40)) - 8'd2;
      stall = $urandom_range(0, 2);
      model(p, i, z, k, l, c, ok, ol, kind, ei, ez, ek, el, stp);
      run_cand(p, 12'(n), i, z, k, l, c, ok, ol, stall, 1'b0, 1'b0);
      want_done = (kind == 0) ? 4 + stall : 3;
      checks++;
      if (o_done_cyc !== want_done) begin
        errors++;
        $display("FAIL rnd%0d_latency: pos=%0d done=%0d want %0d", n, p, o_done_cyc, want_done);
      end
      checks++;
      if (o_push_cyc !== ((kind == 0) ? stall + 1 : 0) || o_unstable !== 0) begin
        errors++;
        $display("FAIL rnd%0d_pushcnt: pos=%0d cycles=%0d unstable=%0d want %0d 0",
                 n, p, o_push_cyc, o_unstable, (kind == 0) ? stall + 1 : 0);
      end
      if (kind == 0) begin
        checks++;
        if ({o_ppos, o_paddr, o_pi, o_pz, o_pk, o_pl} !== {p, 12'(n), ei, ez, ek, el}) begin
          errors++;
          $display("FAIL rnd%0d_push: pos=%0d i=%0d z=%0d k=%0d l=%0d want %0d %0d %0d %0d %0d",
                   n, o_ppos, o_pi, o_pz, o_pk, o_pl, p, ei, ez, ek, el);
        end
      end
      checks++;
      if (o_hit_cnt !== ((kind == 1) ? 1 : 0) || (kind == 1 && {o_hk, o_hl} !== {ek, el})) begin
        errors++;
        $display("FAIL rnd%0d_hit: pos=%0d pulses=%0d k=%0d l=%0d want %0d %0d %0d",
                 n, p, o_hit_cnt, o_hk, o_hl, (kind == 1) ? 1 : 0, ek, el);
      end
      checks++;
      if (o_stop_cnt !== (stp ? 1 : 0) || o_overlap !== 0) begin
        errors++;
        $display("FAIL rnd%0d_stop: pos=%0d stop=%0d overlap=%0d want %0d 0",
                 n, p, o_stop_cnt, o_overlap, stp ? 1 : 0);
      end
    end
  endtask

  initial begin
    pif.push_ready = 1'b0;
    test_reset();
    test_match();
    test_snp_discard();
    test_hit();
    test_insertion_stall();
    test_empty_interval();
    test_stop();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/update_kl.md
Name: update_kl

Overview:
- Pipeline stage directly downstream of the Occ(l) fetch stage in the inexact-search datapath.
- Captures one candidate (position, addr, i, z, k, l) together with three values fetched for the candidate's base: C(b), Occ(b,k-1) and Occ(b,l).
- Computes the new suffix-array interval and new i/z counters, then classifies the candidate. A survivor is pushed to the candidate stack over a valid/ready handshake; a finished alignment is reported as a hit; every other candidate is discarded.
- Pulses done to the controller when the candidate has been fully retired.

Parameters:
- EN_CODE, 3'b101, value of en_update_kl that starts a capture.
- W, 8, width of i/z/k/l/C/Occ fields.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en_update_kl  in  3  stage enable; capture when == EN_CODE
- position  in  5  candidate operation code (shared position defines)
- addr  in  12  candidate parameter address
- i_in  in  W  read index
- z_in  in  W  remaining-difference budget, two's complement
- k_in  in  W  interval lower bound
- l_in  in  W  interval upper bound
- c_base  in  W  C(b) for the position's base
- occ_k  in  W  Occ(b,k-1)
- occ_l  in  W  Occ(b,l), i.e. data_2_out of the Occ(l) fetch stage
- push_valid  out  1  stack push request
- push_ready  in  1  stack accepts push
- push_position  out  5  position passed through
- push_addr  out  12  addr passed through
- push_i  out  W  new i
- push_z  out  W  new z
- push_k  out  W  new k
- push_l  out  W  new l
- hit_valid  out  1  one-cycle pulse, alignment found
- hit_k  out  W  hit interval lower bound
- hit_l  out  W  hit interval upper bound
- stop_seen  out  1  one-cycle pulse, STOP_1/STOP_2 received
- done  out  1  one-cycle pulse, candidate retired
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE and all outputs 0. Reset mid-operation abandons the held candidate and deasserts push_valid in the same edge.
- State IDLE:
  - en_update_kl==EN_CODE at posedge: register all inputs, go to CALC.
  - Any other en_update_kl value: ignored.
  - Enable while not IDLE: ignored, no queuing.
- State CALC (1 cycle) computes the new values by position class:
  - A/C/G/T_MATCH: i'=i-1, z'=z, k'=C+occ_k+1, l'=C+occ_l.
  - A/C/G/T_SNP: i'=i-1, z'=z-1, k'/l' as MATCH.
  - A/C/G/T_DELETION: i'=i, z'=z-1, k'/l' as MATCH.
  - A/C/G/T_INSERTION: i'=i-1, z'=z-1, k'=k, l'=l.
  - NONE, or any undefined code: discard.
  - STOP_1/STOP_2: pulse stop_seen, discard.
  - Arithmetic is done at W+2 bits, unsigned for k/l and signed for z. Going to CHECK.
- State CHECK (1 cycle), classification in priority order:
  1. discard flagged, z'<0, k'>l', or k' or l' >255 → RETIRE.
  2. i was 0 and the position class decrements i → hit_valid=1, hit_k=k', hit_l=l' → RETIRE.
  3. Otherwise → load push_* fields, push_valid=1, go to PUSH.
- State PUSH:
  - push_valid and push_* are held stable until a posedge with push_ready=1.
  - On that edge: push_valid=0, go to RETIRE.
  - push_ready high on the first PUSH cycle completes the push in 1 cycle.
  - No timeout.
- State RETIRE: done=1 for one cycle, then IDLE. A new capture may occur on the posedge after done.
- Latency, enable to done:
  - Discard or hit: 3 cycles.
  - Push with ready already high: 4 cycles.
  - Each stalled push cycle adds 1.
- hit_valid and stop_seen are 1-cycle pulses and never coincide with push_valid.

Test Plan:
- Reset: assert rst_n=0 during PUSH with push_ready=0 → next cycle push_valid=0, busy=0, state IDLE, all outputs 0.
- A_MATCH, i=5 z=1 k=3 l=9, C=10 occ_k=2 occ_l=6, push_ready=1 → push i=4 z=1 k=13 l=16, done 4 cycles after enable.
- C_SNP, z=0, valid interval → z'=-1 → discard. No push, no hit, done at cycle 3.
- G_MATCH, i=0 z=0, C=20 occ_k=4 occ_l=7 → hit_valid pulse, hit_k=25, hit_l=27, no push.
- T_INSERTION, i=3 z=2 k=7 l=7, push_ready low for 3 cycles → push_valid held 3 cycles with i=2 z=1 k=7 l=7 stable. Accepted on 4th cycle, done next cycle.
- Empty interval: A_DELETION, C=5 occ_k=8 occ_l=7 → k'=14 > l'=12 → discard.
- STOP_1 → stop_seen pulse, then done.
- Enable re-asserted while busy → ignored.
